// File: rtl/micro_program_automate_pkg.sv
// Shared types and default timing for the SM2201 microprogram automaton.
package micro_program_automate_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REG,
        ST_WAIT_TIM,
        ST_STROBE1,
        ST_GAP,
        ST_STROBE2,
        ST_CHECK,
        ST_DONE
    } state_e;

    localparam logic [1:0] CAMAC_ADDR = 2'b00;

    localparam int unsigned DEF_SYNC_STAGES = 2;
    localparam int unsigned DEF_C1_CYCLES   = 4;
    localparam int unsigned DEF_GAP_CYCLES  = 2;
    localparam int unsigned DEF_C2_CYCLES   = 4;
    localparam int unsigned DEF_REG_CYCLES  = 3;
    localparam int unsigned DEF_TIM_TIMEOUT = 64;
    localparam int unsigned DEF_RETRY_MAX   = 3;

    // Phase and retry counters; wide enough for any timing constant below 256.
    localparam int unsigned CNT_W = 8;

endpackage

// File: rtl/micro_program_automate_input_sync.sv
// N-stage synchronizer for asynchronous inputs, with selectable reset value.
module micro_program_automate_input_sync #(
    parameter int unsigned          STAGES  = 2,
    parameter int unsigned          WIDTH   = 1,
    parameter logic [WIDTH-1:0]     RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] stage_q [STAGES];

    // Shift chain; first stage samples the raw input.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(STAGES); i++) begin
                stage_q[i] <= RST_VAL;
            end
        end else begin
            stage_q[0] <= d_i;
            for (int i = 1; i < int'(STAGES); i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign q_o = stage_q[STAGES-1];

endmodule

// File: rtl/micro_program_automate.sv
// Control FSM of the SM2201 ISA-CAMAC board: turns an ISA select into a timed
// CAMAC strobe sequence (with X-retry) or a short local register access.
module micro_program_automate
    import micro_program_automate_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int unsigned C1_CYCLES   = DEF_C1_CYCLES,
    parameter int unsigned GAP_CYCLES  = DEF_GAP_CYCLES,
    parameter int unsigned C2_CYCLES   = DEF_C2_CYCLES,
    parameter int unsigned REG_CYCLES  = DEF_REG_CYCLES,
    parameter int unsigned TIM_TIMEOUT = DEF_TIM_TIMEOUT,
    parameter int unsigned RETRY_MAX   = DEF_RETRY_MAX
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] a,
    input  logic       w,
    input  logic       sel,
    input  logic       tim,
    input  logic       ie,
    input  logic       cx1,
    output logic       rdy,
    output logic       c1,
    output logic       c2,
    output logic       sel2,
    output logic       x0,
    output logic       x1
);

    logic [1:0] a_s;
    logic       w_s, sel_s, tim_s, ie_s, cx1_s;

    // sel synchronizer resets high so a select held through reset is not seen as an edge.
    micro_program_automate_input_sync #(.STAGES(SYNC_STAGES), .WIDTH(1), .RST_VAL(1'b1))
        u_sync_sel (.clk(clk), .rst_n(reset), .d_i(sel), .q_o(sel_s));
    micro_program_automate_input_sync #(.STAGES(SYNC_STAGES), .WIDTH(2), .RST_VAL(2'b00))
        u_sync_a   (.clk(clk), .rst_n(reset), .d_i(a),   .q_o(a_s));
    micro_program_automate_input_sync #(.STAGES(SYNC_STAGES), .WIDTH(1), .RST_VAL(1'b0))
        u_sync_w   (.clk(clk), .rst_n(reset), .d_i(w),   .q_o(w_s));
    micro_program_automate_input_sync #(.STAGES(SYNC_STAGES), .WIDTH(1), .RST_VAL(1'b0))
        u_sync_tim (.clk(clk), .rst_n(reset), .d_i(tim), .q_o(tim_s));
    micro_program_automate_input_sync #(.STAGES(SYNC_STAGES), .WIDTH(1), .RST_VAL(1'b0))
        u_sync_ie  (.clk(clk), .rst_n(reset), .d_i(ie),  .q_o(ie_s));
    micro_program_automate_input_sync #(.STAGES(SYNC_STAGES), .WIDTH(1), .RST_VAL(1'b0))
        u_sync_cx1 (.clk(clk), .rst_n(reset), .d_i(cx1), .q_o(cx1_s));

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   retry_q, retry_d;
    logic [1:0]         x_q, x_d;
    logic               w_q, w_d;
    logic               sel_prev_q;
    logic               rdy_q, rdy_d, c1_q, c1_d, c2_q, c2_d, sel2_q, sel2_d;
    logic               sel_rise;
    logic               w_unused;

    // Latched direction is kept for the datapath but not consumed by this block.
    assign w_unused = w_q;
    assign sel_rise = sel_s & ~sel_prev_q;

    // State, counters and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            retry_q    <= '0;
            x_q        <= 2'b00;
            w_q        <= 1'b0;
            sel_prev_q <= 1'b1;
            rdy_q      <= 1'b1;
            c1_q       <= 1'b0;
            c2_q       <= 1'b0;
            sel2_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            retry_q    <= retry_d;
            x_q        <= x_d;
            w_q        <= w_d;
            sel_prev_q <= sel_s;
            rdy_q      <= rdy_d;
            c1_q       <= c1_d;
            c2_q       <= c2_d;
            sel2_q     <= sel2_d;
        end
    end

    // Next-state logic; outputs are decoded from the next state so they register with it.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        retry_d = retry_q;
        x_d     = x_q;
        w_d     = w_q;

        unique case (state_q)
            ST_IDLE: begin
                if (sel_rise) begin
                    x_d     = a_s;
                    w_d     = w_s;
                    retry_d = '0;
                    cnt_d   = '0;
                    state_d = (a_s == CAMAC_ADDR) ? ST_WAIT_TIM : ST_REG;
                end
            end
            ST_REG: begin
                if (cnt_q == CNT_W'(REG_CYCLES - 1)) begin
                    cnt_d   = '0;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_WAIT_TIM: begin
                if (tim_s) begin
                    cnt_d   = '0;
                    state_d = ST_STROBE1;
                end else if (cnt_q == CNT_W'(TIM_TIMEOUT - 1)) begin
                    cnt_d   = '0;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_STROBE1: begin
                if (cnt_q == CNT_W'(C1_CYCLES - 1)) begin
                    cnt_d   = '0;
                    state_d = ST_GAP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_GAP: begin
                if (cnt_q == CNT_W'(GAP_CYCLES - 1)) begin
                    cnt_d   = '0;
                    state_d = ST_STROBE2;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_STROBE2: begin
                if (cnt_q == CNT_W'(C2_CYCLES - 1)) begin
                    cnt_d   = '0;
                    state_d = ST_CHECK;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_CHECK: begin
                if (!cx1_s && ie_s && (retry_q < CNT_W'(RETRY_MAX))) begin
                    retry_d = retry_q + 1'b1;
                    state_d = ST_WAIT_TIM;
                end else begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (!sel_s) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        c1_d   = (state_d == ST_STROBE1);
        c2_d   = (state_d == ST_STROBE2);
        sel2_d = (state_d != ST_IDLE) && (state_d != ST_DONE);
        rdy_d  = ~sel2_d;
    end

    assign rdy  = rdy_q;
    assign c1   = c1_q;
    assign c2   = c2_q;
    assign sel2 = sel2_q;
    assign x0   = x_q[0];
    assign x1   = x_q[1];

endmodule

// File: tb/tb_micro_program_automate.sv
// Bench for micro_program_automate: table of accesses checked through a
// scoreboard queue, plus reset and strobe-shape sequences.
module tb_micro_program_automate;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] a;
    logic       w, sel, tim, ie, cx1;
    logic       rdy, c1, c2, sel2, x0, x1;

    micro_program_automate dut (
        .clk(clk), .reset(reset), .a(a), .w(w), .sel(sel), .tim(tim),
        .ie(ie), .cx1(cx1), .rdy(rdy), .c1(c1), .c2(c2), .sel2(sel2),
        .x0(x0), .x1(x1)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] a;
        logic       w;
        logic       tim;
        logic       ie;
        logic       cx1;
        int         n_c1;
        int         n_c2;
        int         sel2_len;
        logic [1:0] x;
    } vec_t;

    typedef struct {
        int         n_c1;
        int         n_c2;
        int         sel2_len;
        logic [1:0] x;
        int         idx;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    int   overlap_cnt = 0;
    int   outside_cnt = 0;
    int   badlen_cnt  = 0;
    int   badgap_cnt  = 0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: measures each access and compares it with the oldest expectation.
    initial begin
        int   c1_run, c2_run, c1_pulses, c2_pulses, sel2_run, gap_run;
        logic in_gap, prev_rdy;
        exp_t e;
        c1_run = 0; c2_run = 0; c1_pulses = 0; c2_pulses = 0;
        sel2_run = 0; gap_run = 0; in_gap = 1'b0; prev_rdy = 1'b1;
        forever begin
            @(negedge clk);
            if (reset !== 1'b1) begin
                c1_run = 0; c2_run = 0; c1_pulses = 0; c2_pulses = 0;
                sel2_run = 0; gap_run = 0; in_gap = 1'b0; prev_rdy = 1'b1;
            end else begin
                if (c1 && c2) overlap_cnt++;
                if ((c1 || c2) && !sel2) outside_cnt++;
                if (c1) c1_run++;
                else if (c1_run > 0) begin
                    if (c1_run != 4) badlen_cnt++;
                    c1_pulses++;
                    c1_run  = 0;
                    in_gap  = 1'b1;
                    gap_run = 0;
                end
                if (c2) c2_run++;
                else if (c2_run > 0) begin
                    if (c2_run != 4) badlen_cnt++;
                    c2_pulses++;
                    c2_run = 0;
                end
                if (in_gap && !c1 && !c2) gap_run++;
                if (in_gap && c2) begin
                    if (gap_run != 2) badgap_cnt++;
                    in_gap = 1'b0;
                end
                if (sel2) sel2_run++;
                if (!prev_rdy && rdy) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_access", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        check($sformatf("v%0d_c1_pulses", e.idx), c1_pulses, e.n_c1);
                        check($sformatf("v%0d_c2_pulses", e.idx), c2_pulses, e.n_c2);
                        check($sformatf("v%0d_sel2_len", e.idx), sel2_run, e.sel2_len);
                        check($sformatf("v%0d_x", e.idx), int'({x1, x0}), int'(e.x));
                    end
                    c1_pulses = 0; c2_pulses = 0; sel2_run = 0;
                end
                prev_rdy = rdy;
            end
        end
    end

    task automatic run_txn(input vec_t v, input int idx);
        int lat;
        int n;
        a = v.a; w = v.w; tim = v.tim; ie = v.ie; cx1 = v.cx1;
        repeat (4) @(negedge clk);
        exp_q.push_back('{v.n_c1, v.n_c2, v.sel2_len, v.x, idx});
        sel = 1'b1;
        lat = 0;
        while (rdy && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check($sformatf("v%0d_rdy_latency", idx), lat, 3);
        // a and w must be ignored once the access has started
        a = ~v.a;
        w = ~v.w;
        n = 0;
        while (!rdy && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!rdy) check($sformatf("v%0d_rdy_return", idx), 0, 1);
        sel = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got 1 expected 0");
        $fatal(1);
    end

    initial begin
        vec_t vecs[8];
        int   act;
        int   n;

        vecs[0] = '{2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 64, 2'b00}; // tim timeout
        vecs[1] = '{2'b00, 1'b0, 1'b1, 1'b0, 1'b1, 1, 1, 12, 2'b00}; // X present
        vecs[2] = '{2'b00, 1'b1, 1'b1, 1'b1, 1'b0, 4, 4, 48, 2'b00}; // 3 repeats
        vecs[3] = '{2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1, 1, 12, 2'b00}; // no repeat
        vecs[4] = '{2'b10, 1'b1, 1'b1, 1'b0, 1'b0, 0, 0, 3,  2'b10}; // register
        vecs[5] = '{2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 3,  2'b01};
        vecs[6] = '{2'b11, 1'b1, 1'b1, 1'b1, 1'b0, 0, 0, 3,  2'b11};
        vecs[7] = '{2'b00, 1'b1, 1'b1, 1'b1, 1'b1, 1, 1, 12, 2'b00}; // ie but X ok

        reset = 1'b0; sel = 1'b0; a = 2'b00; w = 1'b0;
        tim = 1'b0; ie = 1'b0; cx1 = 1'b0;
        repeat (4) @(negedge clk);
        check("reset_outputs", int'({rdy, c1, c2, sel2, x1, x0}), int'(6'b100000));
        reset = 1'b1;

        // w toggling with sel low must not start anything
        act = 0;
        for (int i = 0; i < 10; i++) begin
            w = ~w;
            @(negedge clk);
            if (!rdy || sel2 || c1 || c2) act++;
        end
        check("idle_w_toggle_activity", act, 0);

        // sel held high across reset is a level, not an edge
        reset = 1'b0;
        sel   = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        act = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (!rdy || sel2) act++;
        end
        check("sel_level_after_reset_activity", act, 0);
        sel = 1'b0;
        repeat (5) @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            run_txn(vecs[i], i);
        end

        // reset asserted during STROBE1
        a = 2'b00; tim = 1'b1; ie = 1'b0; cx1 = 1'b1;
        repeat (4) @(negedge clk);
        sel = 1'b1;
        n = 0;
        while (!c1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("midrst_c1_seen", int'(c1), 1);
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        check("midrst_c1", int'(c1), 0);
        check("midrst_rdy", int'(rdy), 1);
        check("midrst_sel2", int'(sel2), 0);
        sel = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (4) @(negedge clk);
        run_txn(vecs[1], 8);

        repeat (5) @(negedge clk);
        check("scoreboard_empty", exp_q.size(), 0);
        check("strobe_overlap", overlap_cnt, 0);
        check("strobe_outside_access", outside_cnt, 0);
        check("strobe_length", badlen_cnt, 0);
        check("strobe_gap", badgap_cnt, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
